// File: rtl/axis_chan_pkg.sv
// Shared types for the PS<->channel AXI-Stream selector/merger pair.
package axis_chan_pkg;

  localparam int NUM_CH = 16;
  localparam int DATA_W = 256;
  localparam int IDX_W  = $clog2(NUM_CH);

  typedef logic [IDX_W-1:0] chan_idx_t;

  // One beat as it travels through the merger's output slice.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    chan_idx_t         chan;
    logic              trunc;
  } beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered stream slice. The output side is driven purely from
// registers, and the input ready depends only on registered occupancy, so
// the slice breaks both the forward and the backward timing paths while
// still sustaining one beat per cycle.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             skid_valid_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             push;

  // Full only when the skid slot is occupied (which implies the output slot is too).
  assign in_ready_o  = !skid_valid_q;
  assign push        = in_valid_i && !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Refill the output slot from the skid slot first to keep beat order; park new beats in the skid slot while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= push;
        if (push) begin
          out_data_q <= in_data_i;
        end
      end
    end else if (push) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data_i;
    end
  end

endmodule

// File: rtl/axis_channel_merger.sv
// Merges NUM_CH AXI-Stream sources into one stream with packet-granular
// round-robin arbitration, source tagging in tuser and a per-packet beat
// watchdog that force-terminates runaway packets.
module axis_channel_merger #(
  parameter int NUM_CH        = axis_chan_pkg::NUM_CH,
  parameter int DATA_W        = axis_chan_pkg::DATA_W,
  parameter int MAX_PKT_BEATS = 4096
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        channel_enable,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [4:0]               m_axis_tuser,
  input  logic                     m_axis_tready,
  output logic                     busy
);

  import axis_chan_pkg::state_t;
  import axis_chan_pkg::IDLE;
  import axis_chan_pkg::LOCKED;

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int CNT_W  = $clog2(MAX_PKT_BEATS + 1);
  localparam int BEAT_W = DATA_W + IDX_W + 2;

  typedef logic [IDX_W-1:0] idx_t;

  // Local beat layout so the merger follows its own DATA_W/NUM_CH parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    idx_t              chan;
    logic              trunc;
  } merged_beat_t;

  state_t          state_q;
  idx_t            rr_ptr_q;
  idx_t            grant_idx_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d;

  logic [NUM_CH-1:0] cand;
  logic              skid_ready;
  logic              accept;
  logic              src_last;
  logic              wd_hit;
  merged_beat_t      push_beat;
  merged_beat_t      pop_beat;

  // First requester at or after ptr, wrapping; scanning downwards lets the smallest offset win.
  function automatic idx_t rr_pick(input logic [NUM_CH-1:0] req, input idx_t ptr);
    idx_t pick;
    idx_t probe;
    pick = ptr;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      probe = ptr + idx_t'(off);
      if (req[probe]) begin
        pick = probe;
      end
    end
    return pick;
  endfunction

  // Only the locked channel sees ready, and only while the output slice has room.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
    assign s_axis_tready[gi] = (state_q == LOCKED) && (grant_idx_q == idx_t'(gi)) && skid_ready;
  end

  // Beat acceptance, watchdog detection and assembly of the beat pushed into the slice.
  always_comb begin
    cand            = s_axis_tvalid & channel_enable;
    accept          = (state_q == LOCKED) && s_axis_tvalid[grant_idx_q] && skid_ready;
    src_last        = s_axis_tlast[grant_idx_q];
    beat_cnt_d      = beat_cnt_q + 1'b1;
    wd_hit          = !src_last && (beat_cnt_d == CNT_W'(MAX_PKT_BEATS));
    push_beat.data  = s_axis_tdata[grant_idx_q*DATA_W +: DATA_W];
    push_beat.last  = src_last || wd_hit;
    push_beat.chan  = grant_idx_q;
    push_beat.trunc = wd_hit;
  end

  // Arbitration FSM: grant in IDLE, hold the lock until tlast or the watchdog fires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|cand) begin
            grant_idx_q <= rr_pick(cand, rr_ptr_q);
            state_q     <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) begin
            if (src_last || wd_hit) begin
              state_q    <= IDLE;
              rr_ptr_q   <= grant_idx_q + 1'b1;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid_i (accept),
    .in_data_i  (push_beat),
    .in_ready_o (skid_ready),
    .out_valid_o(m_axis_tvalid),
    .out_data_o (pop_beat),
    .out_ready_i(m_axis_tready)
  );

  assign m_axis_tdata = pop_beat.data;
  assign m_axis_tlast = pop_beat.last;
  assign m_axis_tuser = {pop_beat.trunc, 4'(pop_beat.chan)};
  assign busy         = (state_q == LOCKED);

endmodule
